// File: rtl/ofm_pkg.sv
// ============================================================================
// Module      : ofm_pkg
// Description : Shared widths, activation constants and helpers for the OFM
//               post-processing path (bias add, leaky ReLU, requantise).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ofm_pkg;

    localparam int PSUM_WIDTH  = 16;
    localparam int DATA_WIDTH  = 8;
    localparam int SUM_WIDTH   = 18;
    localparam int LEAKY_SHIFT = 3;
    localparam int SAT_MAX     = 127;
    localparam int SAT_MIN     = -128;

    // Index width that stays legal for a single-lane configuration.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ofm_sync_fifo.sv
// ============================================================================
// Module      : ofm_sync_fifo
// Description : Single-clock FIFO with occupancy count; the head is presented
//               combinationally and reads as zero while empty.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ofm_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;
    logic [PTR_W-1:0] w_wr_next;
    logic [PTR_W-1:0] w_rd_next;

    assign w_do_pop  = i_pop && (r_count != '0);
    // A full FIFO may still accept a write when the head leaves on the same edge.
    assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

    assign w_wr_next = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
    assign w_rd_next = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= w_wr_next;
            end
            if (w_do_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid = (r_count != '0);
    assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/ofm_post_process.sv
// ============================================================================
// Module      : ofm_post_process
// Description : Per-lane bias add, optional leaky ReLU, rounding right-shift
//               and int8 saturation, two-stage pipeline into an output FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ofm_post_process #(
    parameter int SYSTOLIC_SIZE = 16,
    parameter int PSUM_WIDTH    = ofm_pkg::PSUM_WIDTH,
    parameter int DATA_WIDTH    = ofm_pkg::DATA_WIDTH,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [SYSTOLIC_SIZE*PSUM_WIDTH-1:0]         in_data,
    input  logic                                        in_last,
    input  logic                                        bias_we,
    input  logic [ofm_pkg::idx_width(SYSTOLIC_SIZE)-1:0] bias_idx,
    input  logic [PSUM_WIDTH-1:0]                       bias_data,
    input  logic [3:0]                                  cfg_shift,
    input  logic                                        cfg_leaky_en,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0]         out_data,
    output logic                                        out_last,
    output logic                                        sat_flag
);

    import ofm_pkg::*;

    localparam int IDX_W  = idx_width(SYSTOLIC_SIZE);
    localparam int RW     = SUM_WIDTH + 1;
    localparam int OUT_W  = SYSTOLIC_SIZE * DATA_WIDTH;
    localparam int BEAT_W = OUT_W + 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int IW     = CNT_W + 1;

    localparam logic signed [RW-1:0] c_sat_max   = RW'(SAT_MAX);
    localparam logic signed [RW-1:0] c_sat_min   = RW'(SAT_MIN);
    localparam logic [IDX_W:0]       c_num_lanes = (IDX_W + 1)'(SYSTOLIC_SIZE);

    logic [PSUM_WIDTH-1:0]    r_bias [SYSTOLIC_SIZE];
    logic                     r_s1_valid;
    logic                     r_s1_last;
    logic [3:0]               r_s1_shift;
    logic                     r_s2_valid;
    logic                     r_s2_last;
    logic [OUT_W-1:0]         r_s2_data;
    logic                     r_sat_flag;

    logic                     w_accept;
    logic [OUT_W-1:0]         w_s2_data;
    logic [SYSTOLIC_SIZE-1:0] w_clip;
    logic [CNT_W-1:0]         w_fifo_count;
    logic [IW-1:0]            w_inflight;
    logic [BEAT_W-1:0]        w_head;

    assign w_accept = in_valid && in_ready;

    // Beats already in the pipeline hold a reserved FIFO slot, so nothing stalls.
    assign w_inflight = IW'(w_fifo_count) + IW'(r_s1_valid) + IW'(r_s2_valid);
    assign in_ready   = (w_inflight < IW'(FIFO_DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYSTOLIC_SIZE; i++) begin
                r_bias[i] <= '0;
            end
        end else if (bias_we && ({1'b0, bias_idx} < c_num_lanes)) begin
            r_bias[bias_idx] <= bias_data;
        end
    end

    for (genvar g = 0; g < SYSTOLIC_SIZE; g++) begin : g_lane
        logic signed [SUM_WIDTH-1:0] w_sum;
        logic signed [SUM_WIDTH-1:0] w_act;
        logic signed [SUM_WIDTH-1:0] r_s1_sum;
        logic signed [RW-1:0]        w_ext;
        logic signed [RW-1:0]        w_rnd;
        logic signed [RW-1:0]        w_shr;
        logic                        w_hi;
        logic                        w_lo;

        assign w_sum = SUM_WIDTH'($signed(in_data[g*PSUM_WIDTH +: PSUM_WIDTH]))
                     + SUM_WIDTH'($signed(r_bias[g]));
        assign w_act = (cfg_leaky_en && w_sum[SUM_WIDTH-1]) ? (w_sum >>> LEAKY_SHIFT) : w_sum;

        always_ff @(posedge clk) begin
            if (w_accept) begin
                r_s1_sum <= w_act;
            end
        end

        // One extra bit of headroom keeps the rounding add from wrapping.
        assign w_ext = RW'(r_s1_sum);
        assign w_rnd = (r_s1_shift == 4'd0) ? '0 : (RW'(1) <<< (r_s1_shift - 4'd1));
        assign w_shr = (w_ext + w_rnd) >>> r_s1_shift;

        assign w_hi      = (w_shr > c_sat_max);
        assign w_lo      = (w_shr < c_sat_min);
        assign w_clip[g] = w_hi | w_lo;
        assign w_s2_data[g*DATA_WIDTH +: DATA_WIDTH] =
            w_hi ? DATA_WIDTH'(SAT_MAX) :
            w_lo ? DATA_WIDTH'(SAT_MIN) : w_shr[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_shift <= 4'd0;
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_data  <= '0;
            r_sat_flag <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_last  <= in_last;
                r_s1_shift <= cfg_shift;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data <= w_s2_data;
                r_s2_last <= r_s1_last;
                if (|w_clip) begin
                    r_sat_flag <= 1'b1;
                end
            end
        end
    end

    ofm_sync_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_s2_valid),
        .i_data  ({r_s2_last, r_s2_data}),
        .i_pop   (out_ready),
        .o_data  (w_head),
        .o_valid (out_valid),
        .o_count (w_fifo_count)
    );

    assign out_data = w_head[OUT_W-1:0];
    assign out_last = w_head[BEAT_W-1];
    assign sat_flag = r_sat_flag;

endmodule

`default_nettype wire

// File: tb/tb_ofm_post_process.sv
// ============================================================================
// Module      : tb_ofm_post_process
// Description : Self-checking bench for ofm_post_process: vector table plus
//               back-pressure, bias-timing and mid-stream reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ofm_post_process;

    localparam int SS = 16;
    localparam int PW = 16;
    localparam int DW = 8;
    localparam int FD = 4;
    localparam int OW = SS * DW;
    localparam int NV = 11;

    typedef struct packed {
        logic [OW-1:0] data;
        logic          last;
    } exp_t;

    typedef struct {
        logic [PW-1:0] psum;
        logic [PW-1:0] bias;
        logic [3:0]    shift;
        logic          leaky;
        logic [7:0]    exp0;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [SS*PW-1:0] in_data;
    logic           in_last;
    logic           bias_we;
    logic [3:0]     bias_idx;
    logic [PW-1:0]  bias_data;
    logic [3:0]     cfg_shift;
    logic           cfg_leaky_en;
    logic           out_valid;
    logic           out_ready;
    logic [OW-1:0]  out_data;
    logic           out_last;
    logic           sat_flag;

    exp_t           q[$];
    exp_t           exp_cur;
    exp_t           exp_head;
    logic [PW-1:0]  bias_model [SS];
    bit             sat_model;
    bit             pend_clip;
    int             tests = 0;
    int             fails = 0;
    int             acc_cnt = 0;
    int             pop_cnt = 0;
    logic [OW-1:0]  last_out = '0;
    vec_t           vecs [NV];

    always #5 clk = ~clk;

    ofm_post_process #(
        .SYSTOLIC_SIZE (SS),
        .PSUM_WIDTH    (PW),
        .DATA_WIDTH    (DW),
        .FIFO_DEPTH    (FD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .bias_we      (bias_we),
        .bias_idx     (bias_idx),
        .bias_data    (bias_data),
        .cfg_shift    (cfg_shift),
        .cfg_leaky_en (cfg_leaky_en),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .sat_flag     (sat_flag)
    );

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] model_lane(input logic [PW-1:0] p, input logic [PW-1:0] b,
                                              input logic [3:0] sh, input logic lk, output bit clip);
        int s;
        s = int'($signed(p)) + int'($signed(b));
        if (lk && s < 0) s = s >>> 3;
        if (sh != 4'd0) s = (s + (1 << (sh - 1))) >>> sh;
        clip = 1'b0;
        if (s > 127) begin
            s = 127;
            clip = 1'b1;
        end else if (s < -128) begin
            s = -128;
            clip = 1'b1;
        end
        return 8'(s);
    endfunction

    // Scoreboard: push when a beat is accepted, pop when the head is consumed.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) begin
                q.push_back(exp_cur);
                acc_cnt++;
            end
            if (out_valid && out_ready) begin
                pop_cnt++;
                last_out = out_data;
                if (q.size() == 0) begin
                    check("spurious_out_valid", OW'(out_valid), OW'(0));
                end else begin
                    exp_head = q.pop_front();
                    check("out_data", out_data, exp_head.data);
                    check("out_last", OW'(out_last), OW'(exp_head.last));
                end
            end
        end
    end

    task automatic drive_beat(input logic [PW-1:0] p0, input logic lst);
        logic [PW-1:0] p;
        logic [OW-1:0] ed;
        bit            clip;
        bit            anyc;
        anyc = 1'b0;
        for (int j = 0; j < SS; j++) begin
            p = p0 + PW'(j * 37);
            in_data[j*PW +: PW] = p;
            ed[j*DW +: DW] = model_lane(p, bias_model[j], cfg_shift, cfg_leaky_en, clip);
            anyc |= clip;
        end
        exp_cur   = '{data: ed, last: lst};
        pend_clip = anyc;
        in_last   = lst;
        in_valid  = 1'b1;
    endtask

    task automatic wait_accept(input int bound);
        bit ok;
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < bound) begin
            @(negedge clk);
            ok = in_ready;
            n++;
        end
        check("accept_within_bound", OW'(ok), OW'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (ok) sat_model |= pend_clip;
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while (q.size() != 0 && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_within_bound", OW'(q.size()), OW'(0));
    endtask

    task automatic write_bias(input logic [3:0] idx, input logic [PW-1:0] val);
        bias_we   = 1'b1;
        bias_idx  = idx;
        bias_data = val;
        @(posedge clk);
        #1;
        bias_we = 1'b0;
        bias_model[idx] = val;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int p0;
        int nv;

        vecs[0]  = '{16'd100,  16'd28,   4'd4,  1'b0, 8'h08};
        vecs[1]  = '{16'hFCE0, 16'd0,    4'd0,  1'b1, 8'h9C};
        vecs[2]  = '{16'hFCE0, 16'd0,    4'd0,  1'b0, 8'h80};
        vecs[3]  = '{16'h7FFF, 16'h7FFF, 4'd0,  1'b0, 8'h7F};
        vecs[4]  = '{16'h8000, 16'h8000, 4'd0,  1'b0, 8'h80};
        vecs[5]  = '{16'd50,   16'hFFF6, 4'd1,  1'b0, 8'h14};
        vecs[6]  = '{16'hFFDB, 16'd0,    4'd2,  1'b1, 8'hFF};
        vecs[7]  = '{16'd1000, 16'd0,    4'd15, 1'b0, 8'h00};
        vecs[8]  = '{16'hBFFF, 16'd0,    4'd15, 1'b0, 8'hFF};
        vecs[9]  = '{16'd24,   16'd0,    4'd4,  1'b0, 8'h02};
        vecs[10] = '{16'hFFE8, 16'd0,    4'd4,  1'b0, 8'hFF};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        bias_we = 1'b0; bias_idx = '0; bias_data = '0;
        cfg_shift = '0; cfg_leaky_en = 1'b0; out_ready = 1'b0;
        exp_cur = '0; sat_model = 1'b0; pend_clip = 1'b0;
        for (int j = 0; j < SS; j++) bias_model[j] = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("reset_out_valid", OW'(out_valid), OW'(0));
        check("reset_out_data",  out_data, OW'(0));
        check("reset_out_last",  OW'(out_last), OW'(0));
        check("reset_in_ready",  OW'(in_ready), OW'(1));
        check("reset_sat_flag",  OW'(sat_flag), OW'(0));

        // Table: single beats with an idle pipeline, so latency is fixed.
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            write_bias(4'd0, vecs[i].bias);
            cfg_shift    = vecs[i].shift;
            cfg_leaky_en = vecs[i].leaky;
            drive_beat(vecs[i].psum, 1'b1);
            wait_accept(10);
            @(posedge clk); #1;
            check($sformatf("vec%0d_valid_after_k1", i), OW'(out_valid), OW'(0));
            @(posedge clk); #1;
            check($sformatf("vec%0d_valid_after_k2", i), OW'(out_valid), OW'(1));
            drain(20);
            check($sformatf("vec%0d_lane0", i), OW'(last_out[7:0]), OW'(vecs[i].exp0));
            check($sformatf("vec%0d_sat_flag", i), OW'(sat_flag), OW'(sat_model));
        end

        // Bias written on the accept edge of beat A only affects the next beat.
        cfg_shift = 4'd0; cfg_leaky_en = 1'b0;
        bias_we = 1'b1; bias_idx = 4'd3; bias_data = 16'd5;
        drive_beat(16'd0, 1'b0);
        wait_accept(10);
        bias_we = 1'b0;
        bias_model[3] = 16'd5;
        drain(20);
        check("biasA_lane3", OW'(last_out[31:24]), OW'(8'd111));
        drive_beat(16'd0, 1'b0);
        wait_accept(10);
        drain(20);
        check("biasB_lane3", OW'(last_out[31:24]), OW'(8'd116));

        // Back-pressure: 4 accepted while blocked, then 6 emerge in order.
        out_ready = 1'b0;
        a0 = acc_cnt;
        p0 = pop_cnt;
        for (int b = 0; b < 4; b++) begin
            drive_beat(PW'(b * 16), 1'b0);
            wait_accept(10);
        end
        drive_beat(PW'(64), 1'b0);
        repeat (6) @(negedge clk);
        check("accepted_while_blocked", OW'(acc_cnt - a0), OW'(4));
        check("in_ready_when_full", OW'(in_ready), OW'(0));
        check("out_valid_when_full", OW'(out_valid), OW'(1));
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_accept(20);
        drive_beat(PW'(80), 1'b1);
        wait_accept(10);
        drain(40);
        check("beats_emerged", OW'(pop_cnt - p0), OW'(6));

        // Reset with two beats in the FIFO and two in the pipeline.
        write_bias(4'd0, 16'd28);
        out_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            drive_beat(PW'(b), 1'b0);
            wait_accept(10);
        end
        check("in_ready_before_rst", OW'(in_ready), OW'(0));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        sat_model = 1'b0;
        for (int j = 0; j < SS; j++) bias_model[j] = '0;
        check("rst_in_ready",  OW'(in_ready), OW'(1));
        check("rst_sat_flag",  OW'(sat_flag), OW'(0));
        check("rst_out_valid", OW'(out_valid), OW'(0));
        check("rst_out_data",  out_data, OW'(0));
        check("rst_out_last",  OW'(out_last), OW'(0));
        out_ready = 1'b1;
        nv = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        check("no_output_after_rst", OW'(nv), OW'(0));
        @(posedge clk); #1;
        drive_beat(16'd100, 1'b1);
        wait_accept(10);
        drain(20);
        check("post_rst_lane0_bias_cleared", OW'(last_out[7:0]), OW'(8'h64));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
